protocol_frame_decoder: RTL and testbench

Sequential successor of the combinational command-to-response decoder. Assembles two-byte host frames (address, command) from the UART receiver and issues read requests to the sensor front-end. Returns a two-byte response (code, value) to the UART transmitter through a valid/ready handshake. Supports per-request sensor addressing, timeouts and an optional periodic continuous-report mode.

---
 rtl/protocol_frame_decoder.sv | 232 +++++++++++++++++++++++
 tb/tb_protocol_frame_decoder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/protocol_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module  : protocol_frame_decoder
// Desc    : Assembles (address, command) host frames, runs sensor reads and
//           returns a (code, value) response over valid/ready. Optional macro
//           CONT_MODE_EN adds periodic continuous reports.
// Rev     : 1.0  initial release
// ============================================================================
module protocol_frame_decoder #(
  parameter int NUM_SENSORS    = 32,
  parameter int ADDR_W         = 5,
  parameter int BYTE_TIMEOUT   = 50000,
  parameter int SENSOR_TIMEOUT = 5000000,
  parameter int CONT_PERIOD    = 50000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_overrun,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              sensor_req,
  output logic [ADDR_W-1:0] sensor_addr,
  output logic              sensor_sel,
  input  logic              sensor_done,
  input  logic              sensor_err,
  input  logic [7:0]        sensor_data,
  output logic              busy
);
  localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
  localparam int ST_W = $clog2(SENSOR_TIMEOUT + 1);
  localparam logic [BT_W-1:0] c_byte_max  = BT_W'(BYTE_TIMEOUT);
  localparam logic [ST_W-1:0] c_sens_last = ST_W'(SENSOR_TIMEOUT - 1);
  localparam logic [ST_W-1:0] c_sens_max  = ST_W'(SENSOR_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_GET_CMD   = 3'd1,
    S_DECODE    = 3'd2,
    S_REQ       = 3'd3,
    S_WAIT      = 3'd4,
    S_SEND_CODE = 3'd5,
    S_SEND_VAL  = 3'd6
  } state_t;

  state_t            r_state, w_next;
  logic [7:0]        r_addr_byte, r_cmd, r_code, r_value;
  logic [ADDR_W-1:0] r_sensor_addr;
  logic              r_sensor_sel;
  logic [BT_W-1:0]   r_byte_timer;
  logic [ST_W-1:0]   r_sens_timer;
  logic              w_read, w_sel, w_start, w_stop, w_sens_to, w_err;
  logic [7:0]        w_code, w_value;
  logic              w_cont_fire, w_cont_sel;
  logic [ADDR_W-1:0] w_cont_addr;

  assign sensor_addr = r_sensor_addr;
  assign sensor_sel  = r_sensor_sel;
  assign w_sens_to   = (r_sens_timer == c_sens_last);
  assign w_err       = (r_state == S_WAIT) &&
                       ((sensor_done && sensor_err) || (!sensor_done && w_sens_to));

  // Command decode of the latched frame; anything unrecognised echoes the command.
  always_comb begin
    w_read  = 1'b0;
    w_sel   = 1'b0;
    w_start = 1'b0;
    w_stop  = 1'b0;
    w_code  = 8'hEE;
    if (32'(r_addr_byte) < NUM_SENSORS) begin
      case (r_cmd)
        8'h00: begin w_read = 1'b1; w_code = 8'h07; end
        8'h01: begin w_read = 1'b1; w_code = 8'h09; end
        8'h02: begin w_read = 1'b1; w_sel = 1'b1; w_code = 8'h08; end
`ifdef CONT_MODE_EN
        8'h03: begin w_read = 1'b1; w_start = 1'b1; w_code = 8'h0D; end
        8'h04: begin w_read = 1'b1; w_start = 1'b1; w_sel = 1'b1; w_code = 8'h0E; end
        8'h05: begin w_stop = 1'b1; w_code = 8'h0A; end
        8'h06: begin w_stop = 1'b1; w_sel = 1'b1; w_code = 8'h0B; end
`endif
        default: ;
      endcase
    end
    w_value = (w_code == 8'hEE) ? r_cmd : 8'h00;
  end

`ifdef CONT_MODE_EN
  localparam int CP_W = $clog2(CONT_PERIOD + 1);
  localparam logic [CP_W-1:0] c_cont_max = CP_W'(CONT_PERIOD);

  logic              r_cont_active, r_cont_sel;
  logic [ADDR_W-1:0] r_cont_addr;
  logic [CP_W-1:0]   r_cont_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cont_active <= 1'b0;
      r_cont_sel    <= 1'b0;
      r_cont_addr   <= '0;
      r_cont_cnt    <= '0;
    end else begin
      if (w_cont_fire || !r_cont_active) r_cont_cnt <= '0;
      else if (r_cont_cnt != c_cont_max) r_cont_cnt <= r_cont_cnt + 1'b1;
      if (r_state == S_DECODE && w_start) begin
        r_cont_active <= 1'b1;
        r_cont_addr   <= r_addr_byte[ADDR_W-1:0];
        r_cont_sel    <= w_sel;
        r_cont_cnt    <= '0;
      end else if (r_state == S_DECODE && w_stop && r_cont_sel == w_sel) begin
        r_cont_active <= 1'b0;
      end else if (w_err) begin
        r_cont_active <= 1'b0;
      end
    end
  end

  // A host byte arriving in the same cycle wins over a due report.
  assign w_cont_fire = r_cont_active && (r_cont_cnt == c_cont_max) &&
                       (r_state == S_IDLE) && !rx_valid;
  assign w_cont_addr = r_cont_addr;
  assign w_cont_sel  = r_cont_sel;
`else
  logic [33:0] w_unused_cont;
  assign w_unused_cont = {32'(CONT_PERIOD), w_start, w_stop};
  assign w_cont_fire   = 1'b0;
  assign w_cont_addr   = '0;
  assign w_cont_sel    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr_byte   <= '0;
      r_cmd         <= '0;
      r_code        <= '0;
      r_value       <= '0;
      r_sensor_addr <= '0;
      r_sensor_sel  <= 1'b0;
      r_byte_timer  <= '0;
      r_sens_timer  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (rx_valid) begin
            r_addr_byte  <= rx_data;
            r_byte_timer <= '0;
          end else if (w_cont_fire) begin
            r_sensor_addr <= w_cont_addr;
            r_sensor_sel  <= w_cont_sel;
            r_code        <= w_cont_sel ? 8'h08 : 8'h09;
          end
        end
        S_GET_CMD: begin
          if (rx_valid) r_cmd <= rx_data;
          else if (r_byte_timer != c_byte_max) r_byte_timer <= r_byte_timer + 1'b1;
        end
        S_DECODE: begin
          r_code  <= w_code;
          r_value <= w_value;
          if (w_read) begin
            r_sensor_addr <= r_addr_byte[ADDR_W-1:0];
            r_sensor_sel  <= w_sel;
          end
        end
        S_REQ: r_sens_timer <= '0;
        S_WAIT: begin
          if (sensor_done) begin
            if (sensor_err) begin
              r_code  <= 8'h1F;
              r_value <= 8'h00;
            end else begin
              r_value <= sensor_data;
            end
          end else if (w_sens_to) begin
            r_code  <= 8'h1F;
            r_value <= 8'h00;
          end else if (r_sens_timer != c_sens_max) begin
            r_sens_timer <= r_sens_timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next     = r_state;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    sensor_req = 1'b0;
    busy       = 1'b1;
    rx_overrun = 1'b0;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (rx_valid)         w_next = S_GET_CMD;
        else if (w_cont_fire) w_next = S_REQ;
      end
      S_GET_CMD: begin
        busy = 1'b0;
        if (rx_valid)                          w_next = S_DECODE;
        else if (r_byte_timer == c_byte_max)   w_next = S_IDLE;
      end
      S_DECODE: w_next = w_read ? S_REQ : S_SEND_CODE;
      S_REQ: begin
        sensor_req = 1'b1;
        w_next     = S_WAIT;
      end
      S_WAIT: if (sensor_done || w_sens_to) w_next = S_SEND_CODE;
      S_SEND_CODE: begin
        tx_valid = 1'b1;
        tx_data  = r_code;
        if (tx_ready) w_next = S_SEND_VAL;
      end
      S_SEND_VAL: begin
        tx_valid = 1'b1;
        tx_data  = r_value;
        if (tx_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
    rx_overrun = rx_valid && busy;
  end

endmodule
`default_nettype wire

// File: tb/tb_protocol_frame_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_protocol_frame_decoder
// Desc    : Directed + randomized frames against a table-driven response model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_protocol_frame_decoder;
  localparam int NUM_SENSORS    = 32;
  localparam int ADDR_W         = 5;
  localparam int BYTE_TIMEOUT   = 20;
  localparam int SENSOR_TIMEOUT = 100;
  localparam int CONT_PERIOD    = 200;
`ifdef CONT_MODE_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif

  logic              clk = 1'b0, rst_n = 1'b0;
  logic [7:0]        rx_data = 8'h00;
  logic              rx_valid = 1'b0, tx_ready = 1'b0;
  logic              sensor_done = 1'b0, sensor_err = 1'b0;
  logic [7:0]        sensor_data = 8'h00;
  logic              rx_overrun, tx_valid, sensor_req, sensor_sel, busy;
  logic [7:0]        tx_data;
  logic [ADDR_W-1:0] sensor_addr;
  int                checks = 0, errors = 0, cyc = 0;

  protocol_frame_decoder #(
    .NUM_SENSORS(NUM_SENSORS), .ADDR_W(ADDR_W), .BYTE_TIMEOUT(BYTE_TIMEOUT),
    .SENSOR_TIMEOUT(SENSOR_TIMEOUT), .CONT_PERIOD(CONT_PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_overrun(rx_overrun), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .sensor_req(sensor_req), .sensor_addr(sensor_addr),
    .sensor_sel(sensor_sel), .sensor_done(sensor_done), .sensor_err(sensor_err),
    .sensor_data(sensor_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Response rules as a lookup: which commands read, which sensor, which code.
  task automatic model(input logic [7:0] a, input logic [7:0] c, input int mode,
                       input logic [7:0] d, output bit rd, output bit sel,
                       output logic [7:0] code, output logic [7:0] val);
    logic [7:0] ok_code [0:6] = '{8'h07, 8'h09, 8'h08, 8'h0D, 8'h0E, 8'h0A, 8'h0B};
    rd = 1'b0; sel = 1'b0; code = 8'hEE; val = c;
    if (a < NUM_SENSORS && (c <= 8'd2 || (CONT && c <= 8'd6))) begin
      code = ok_code[c[2:0]];
      val  = 8'h00;
      rd   = (c <= 8'd4);
      sel  = (c == 8'd2 || c == 8'd4);
      if (rd && mode == 0) val = d;
      else if (rd) begin code = 8'h1F; val = 8'h00; end
    end
  endtask

  task automatic recv_byte(input string tag, input logic [7:0] exp, input int stall);
    logic [7:0] first;
    int n = 0;
    while (!tx_valid && n < 50) begin tick(); n++; end
    chk({tag, "_valid"}, 32'(tx_valid), 32'd1);
    first    = tx_data;
    tx_ready = 1'b0;
    for (int i = 0; i < stall; i++) tick();
    if (stall > 0) begin
      chk({tag, "_hold_valid"}, 32'(tx_valid), 32'd1);
      chk({tag, "_hold_data"}, 32'(tx_data), 32'(first));
    end
    repeat ($urandom_range(0, 2)) tick();
    chk({tag, "_data"}, 32'(tx_data), 32'(exp));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
  endtask

  task automatic run_txn(input string tag, input bit exp_rd, input logic [ADDR_W-1:0] exp_addr,
                         input bit exp_sel, input logic [7:0] exp_code, input logic [7:0] exp_val,
                         input int mode, input logic [7:0] d, input bit inj, input int stall,
                         input int bound, output int req_cyc);
    bit got_req = 1'b0;
    int cd = 0, n = 0, t_req = 0;
    req_cyc = 0;
    while (!tx_valid && n < bound) begin
      sensor_done = 1'b0;
      sensor_err  = 1'b0;
      if (cd == 1) begin
        sensor_done = 1'b1;
        sensor_err  = (mode == 1);
        sensor_data = d;
        chk({tag, "_addr_hold"}, 32'(sensor_addr), 32'(exp_addr));
      end
      if (inj && cd == 4) begin
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        #1;
        chk({tag, "_overrun"}, 32'(rx_overrun), 32'd1);
      end else rx_valid = 1'b0;
      if (cd > 0) cd--;
      if (sensor_req) begin
        got_req = 1'b1;
        t_req   = n;
        req_cyc = cyc;
        if (exp_rd) begin
          chk({tag, "_addr"}, 32'(sensor_addr), 32'(exp_addr));
          chk({tag, "_sel"}, 32'(sensor_sel), 32'(exp_sel));
        end
        cd = (mode == 2) ? 0 : (inj ? 6 : int'($urandom_range(1, 4)));
      end
      tick();
      n++;
    end
    sensor_done = 1'b0;
    sensor_err  = 1'b0;
    rx_valid    = 1'b0;
    chk({tag, "_req"}, 32'(got_req), 32'(exp_rd));
    if (!tx_valid) begin
      chk({tag, "_resp_timeout"}, 32'(tx_valid), 32'd1);
    end else begin
      if (mode == 2 && exp_rd)
        chk({tag, "_to_latency"},
            32'((n - t_req) >= SENSOR_TIMEOUT && (n - t_req) <= SENSOR_TIMEOUT + 2), 32'd1);
      recv_byte({tag, "_code"}, exp_code, stall);
      chk({tag, "_val_latency"}, 32'(tx_valid), 32'd1);
      recv_byte({tag, "_value"}, exp_val, 0);
      chk({tag, "_busy_end"}, 32'({busy, tx_valid}), 32'd0);
    end
  endtask

  task automatic do_frame(input string tag, input logic [7:0] a, input logic [7:0] c,
                          input int mode, input logic [7:0] d, input bit inj, input int stall,
                          output int req_cyc);
    bit rd, sel;
    logic [7:0] code, val;
    model(a, c, mode, d, rd, sel, code, val);
    send_byte(a);
    send_byte(c);
    run_txn(tag, rd, a[ADDR_W-1:0], sel, code, val, mode, d, inj, stall, 300, req_cyc);
  endtask

  task automatic quiet(input string tag, input int cycles);
    bit any = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      any = any | tx_valid | sensor_req;
      tick();
    end
    chk(tag, 32'(any), 32'd0);
  endtask

  initial begin
    int rc, r1, r2, n;
    logic [7:0] a, c, d;
    repeat (3) tick();
    chk("reset_outputs",
        32'({tx_valid, sensor_req, rx_overrun, busy, sensor_sel, sensor_addr, tx_data}), 32'd0);
    rst_n = 1'b1;
    tick();

    do_frame("temp_read", 8'h02, 8'h01, 0, 8'h19, 1'b0, 0, rc);
    do_frame("bad_addr", 8'h20, 8'h01, 0, 8'h00, 1'b0, 0, rc);
    do_frame("sens_err", 8'h03, 8'h02, 1, 8'h5A, 1'b0, 0, rc);
    do_frame("sens_timeout", 8'h03, 8'h02, 2, 8'h00, 1'b0, 0, rc);

    send_byte(8'h07);
    quiet("byte_timeout_silent", BYTE_TIMEOUT + 5);
    do_frame("after_byte_timeout", 8'h00, 8'h02, 0, 8'h3C, 1'b0, 0, rc);

    do_frame("status_stall", 8'h05, 8'h00, 0, 8'h77, 1'b0, 10, rc);
    do_frame("overrun_wait", 8'h09, 8'h01, 0, 8'h81, 1'b1, 0, rc);

    for (int i = 0; i < 12; i++) begin
      a = 8'($urandom_range(0, 39));
      case ($urandom_range(0, 3))
        0, 2:    c = 8'($urandom_range(0, 2));
        1:       c = 8'($urandom_range(7, 255));
        default: c = CONT ? 8'h07 : 8'($urandom_range(3, 6));
      endcase
      d = 8'($urandom);
      do_frame("random", a, c, int'($urandom_range(0, 2)), d, 1'b0, int'($urandom_range(0, 2)), rc);
    end

    send_byte(8'h02);
    send_byte(8'h01);
    n = 0;
    while (!sensor_req && n < 20) begin tick(); n++; end
    tick();
    sensor_done = 1'b1;
    sensor_data = 8'h33;
    tick();
    sensor_done = 1'b0;
    chk("pre_reset_valid", 32'(tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({tx_valid, busy, tx_data}), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    do_frame("after_reset", 8'h1F, 8'h02, 0, 8'hC4, 1'b0, 0, rc);

`ifdef CONT_MODE_EN
    do_frame("cont_start_hum", 8'h01, 8'h04, 0, 8'h42, 1'b0, 0, rc);
    d = 8'($urandom);
    run_txn("cont_report1", 1'b1, 5'd1, 1'b1, 8'h08, d, 0, d, 1'b0, 0, 400, r1);
    do_frame("cont_stop_mismatch", 8'h01, 8'h05, 0, 8'h00, 1'b0, 0, rc);
    d = 8'($urandom);
    run_txn("cont_report2", 1'b1, 5'd1, 1'b1, 8'h08, d, 0, d, 1'b0, 0, 400, r2);
    chk("cont_period", 32'((r2 - r1) >= CONT_PERIOD - 5 && (r2 - r1) <= CONT_PERIOD + 15), 32'd1);
    do_frame("cont_stop_hum", 8'h01, 8'h06, 0, 8'h00, 1'b0, 0, rc);
    quiet("cont_stopped", 2 * CONT_PERIOD + 50);

    do_frame("cont_start_temp", 8'h04, 8'h03, 0, 8'h11, 1'b0, 0, rc);
    n = 0;
    while (!sensor_req && n < 2 * CONT_PERIOD) begin tick(); n++; end
    chk("cont_temp_req", 32'({sensor_req, sensor_sel, sensor_addr}), 32'({1'b1, 1'b0, 5'd4}));
    tick();
    sensor_done = 1'b1;
    sensor_data = 8'h66;
    tick();
    sensor_done = 1'b0;
    chk("cont_temp_code", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h09}));
    rst_n = 1'b0;
    #1;
    chk("cont_reset_valid", 32'(tx_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    quiet("cont_off_after_reset", 2 * CONT_PERIOD + 50);
`else
    do_frame("no_cont_start", 8'h01, 8'h04, 0, 8'h00, 1'b0, 0, rc);
    do_frame("no_cont_stop", 8'h01, 8'h06, 0, 8'h00, 1'b0, 0, rc);
    quiet("no_cont_reports", CONT_PERIOD + 20);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
